// File: rtl/w_update_gen.sv
// LMS weight-update engine for the 2-bit-coded FIR filter.
// Sweeps one tap per cycle per error sample and sends only the tap codes that changed.
module w_update_gen #(
  parameter int N        = 1008,
  parameter int ERR_W    = 16,
  parameter int ACC_W    = 24,
  parameter int MU_SHIFT = 8,
  parameter int THR      = 2 ** (ACC_W - 3),
  localparam int IDX_W   = $clog2(N)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    valid_data_in,
  input  logic [1:0]              data_in,
  input  logic                    valid_err_in,
  input  logic signed [ERR_W-1:0] err_in,
  input  logic                    resync,
  output logic                    valid_update_out,
  output logic [IDX_W-1:0]        update_idx,
  output logic [1:0]              update_data,
  output logic                    busy,
  output logic                    sweep_done,
  output logic                    err_drop
);

  // Wide enough that neither the product nor acc+d can overflow before saturation.
  localparam int SW = (ACC_W + 1 > ERR_W + 3) ? ACC_W + 1 : ERR_W + 3;
  localparam logic signed [SW-1:0] ACC_MAX = {{(SW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};
  localparam logic signed [SW-1:0] THR_POS = SW'(THR);
  localparam logic signed [SW-1:0] THR_NEG = -THR_POS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    RESEND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ERR_W-1:0] err_q;
  logic                    accept, drop, lastTap, emit;

  logic [1:0]              hist_q   [N];
  logic [1:0]              snap_q   [N];
  logic [1:0]              mirror_q [N];
  logic [ACC_W-1:0]        acc_q    [N];

  logic                    valid_q, done_q, drop_q;
  logic [IDX_W-1:0]        uidx_q;
  logic [1:0]              udata_q;

  logic [1:0]              x, code, outCode, mirrorCur;
  logic signed [ERR_W+1:0] errExt, errX3, pMag, p;
  logic signed [SW-1:0]    pExt, d, accExt, sum, accNew;

  assign lastTap = (idx_q == IDX_W'(N - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (resync) begin
          state_d = RESEND;
          idx_d   = '0;
          drop    = valid_err_in;
        end else if (valid_err_in) begin
          state_d = SWEEP;
          idx_d   = '0;
          accept  = 1'b1;
        end
      end
      SWEEP, RESEND: begin
        drop = valid_err_in;
        if (lastTap) state_d = IDLE;
        else         idx_d   = idx_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-tap datapath: err * x, shift by mu, saturating accumulate, requantise.
  always_comb begin
    x         = snap_q[idx_q];
    mirrorCur = mirror_q[idx_q];
    errExt    = {{2{err_q[ERR_W-1]}}, err_q};
    errX3     = errExt + (errExt <<< 1);
    pMag      = x[0] ? errX3 : errExt;
    p         = x[1] ? -pMag : pMag;
    pExt      = {{(SW - ERR_W - 2){p[ERR_W+1]}}, p};
    d         = pExt >>> MU_SHIFT;
    accExt    = {{(SW - ACC_W){acc_q[idx_q][ACC_W-1]}}, acc_q[idx_q]};
    sum       = accExt + d;
    if (sum > ACC_MAX)      accNew = ACC_MAX;
    else if (sum < ACC_MIN) accNew = ACC_MIN;
    else                    accNew = sum;
    code      = {accNew[SW-1], (accNew >= THR_POS) || (accNew <= THR_NEG)};
    outCode   = (state_q == SWEEP) ? code : mirrorCur;
    emit      = (state_q == RESEND) || ((state_q == SWEEP) && (code != mirrorCur));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      uidx_q  <= '0;
      udata_q <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) err_q <= err_in;
      valid_q <= emit;
      if (emit) begin
        uidx_q  <= idx_q;
        udata_q <= outCode;
      end
      done_q  <= (state_q != IDLE) && lastTap;
      drop_q  <= drop;
    end
  end

  // History keeps shifting during a sweep; the sweep reads the snapshot instead.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        hist_q[i]   <= 2'b00;
        snap_q[i]   <= 2'b00;
        mirror_q[i] <= 2'b00;
        acc_q[i]    <= '0;
      end
    end else begin
      if (valid_data_in) begin
        for (int i = N - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
        hist_q[0] <= data_in;
      end
      if (accept) snap_q <= hist_q;
      if (state_q == SWEEP) begin
        acc_q[idx_q] <= accNew[ACC_W-1:0];
        if (emit) mirror_q[idx_q] <= code;
      end
    end
  end

  assign valid_update_out = valid_q;
  assign update_idx       = uidx_q;
  assign update_data      = udata_q;
  assign busy             = (state_q != IDLE);
  assign sweep_done       = done_q;
  assign err_drop         = drop_q;

endmodule

// File: tb/tb_w_update_gen.sv
// Self-checking bench for w_update_gen with a small 4-tap configuration.
module tb_w_update_gen;

  localparam int N = 4, ERR_W = 16, ACC_W = 8, MU = 0, THR = 32, IW = 2;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    valid_data_in = 1'b0;
  logic [1:0]              data_in = 2'b00;
  logic                    valid_err_in = 1'b0;
  logic signed [ERR_W-1:0] err_in = '0;
  logic                    resync = 1'b0;
  logic                    valid_update_out;
  logic [IW-1:0]           update_idx;
  logic [1:0]              update_data;
  logic                    busy, sweep_done, err_drop;

  int nCmp = 0, nFail = 0;

  int         mAcc    [N];
  logic [1:0] mMirror [N];
  logic [1:0] mHist   [N];
  logic       expV    [N];
  logic [1:0] expC    [N];

  always #5 clock = ~clock;

  w_update_gen #(.N(N), .ERR_W(ERR_W), .ACC_W(ACC_W), .MU_SHIFT(MU), .THR(THR)) dut (
    .clock(clock), .reset_n(reset_n), .valid_data_in(valid_data_in), .data_in(data_in),
    .valid_err_in(valid_err_in), .err_in(err_in), .resync(resync),
    .valid_update_out(valid_update_out), .update_idx(update_idx), .update_data(update_data),
    .busy(busy), .sweep_done(sweep_done), .err_drop(err_drop)
  );

  function automatic int codeVal(input logic [1:0] c);
    case (c)
      2'b00:   return 1;
      2'b01:   return 3;
      2'b10:   return -1;
      default: return -3;
    endcase
  endfunction

  function automatic logic [1:0] codeOf(input int s);
    return {s < 0, (s >= THR) || (s <= -THR)};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic modelClear;
    for (int i = 0; i < N; i++) begin
      mAcc[i] = 0; mMirror[i] = 2'b00; mHist[i] = 2'b00;
    end
  endtask

  task automatic modelShift(input logic [1:0] c);
    for (int i = N - 1; i > 0; i--) mHist[i] = mHist[i-1];
    mHist[0] = c;
  endtask

  task automatic pushData(input logic [1:0] c);
    valid_data_in = 1'b1; data_in = c;
    tick;
    valid_data_in = 1'b0;
    modelShift(c);
  endtask

  // Predicts every slot of one sweep from the history seen at acceptance.
  task automatic modelSweep(input int err, input bit resend);
    int s;
    logic [1:0] c;
    for (int k = 0; k < N; k++) begin
      if (resend) begin
        expV[k] = 1'b1; expC[k] = mMirror[k];
      end else begin
        s = mAcc[k] + ((err * codeVal(mHist[k])) >>> MU);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        mAcc[k] = s;
        c = codeOf(s);
        expV[k] = (c != mMirror[k]);
        expC[k] = c;
        if (expV[k]) mMirror[k] = c;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    nCmp++;
    if ({valid_update_out, update_idx, update_data, busy, sweep_done, err_drop} !== '0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs: got v=%b idx=%0d d=%b busy=%b done=%b drop=%b, want all 0",
               valid_update_out, update_idx, update_data, busy, sweep_done, err_drop);
    end
    @(negedge clock);
    reset_n = 1'b1;
    modelClear();
  endtask

  task automatic test_resync;
    resync = 1'b1;
    modelSweep(0, 1'b1);
    tick;
    resync = 1'b0;
    nCmp++;
    if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL resync_busy: got %b want 1", busy); end
    for (int k = 0; k < N; k++) begin
      tick;
      nCmp++;
      if (valid_update_out !== expV[k] || (expV[k] && (update_idx !== IW'(k) || update_data !== expC[k])) || sweep_done !== (k == N - 1)) begin
        nFail++;
        $display("[TB] FAIL resync_slot%0d: got v=%b idx=%0d d=%b done=%b want v=%b idx=%0d d=%b done=%b",
                 k, valid_update_out, update_idx, update_data, sweep_done, expV[k], k, expC[k], k == N - 1);
      end
    end
    nCmp++;
    if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL resync_idle: got busy=%b want 0", busy); end
  endtask

  // History 01,00,10,11 (hist[0]=11) with err +12, then err -40 twice to saturate.
  task automatic test_directed_and_saturation;
    logic [1:0] pat [4];
    int errs [3];
    pat = '{2'b01, 2'b00, 2'b10, 2'b11};
    errs = '{12, -40, -40};
    for (int i = 0; i < 4; i++) pushData(pat[i]);
    for (int e = 0; e < 3; e++) begin
      valid_err_in = 1'b1; err_in = 16'(errs[e]);
      modelSweep(errs[e], 1'b0);
      tick;
      valid_err_in = 1'b0;
      for (int k = 0; k < N; k++) begin
        tick;
        nCmp++;
        if (valid_update_out !== expV[k] || (expV[k] && (update_idx !== IW'(k) || update_data !== expC[k])) || sweep_done !== (k == N - 1)) begin
          nFail++;
          $display("[TB] FAIL directed%0d_slot%0d: got v=%b idx=%0d d=%b done=%b want v=%b idx=%0d d=%b done=%b",
                   e, k, valid_update_out, update_idx, update_data, sweep_done, expV[k], k, expC[k], k == N - 1);
        end
        if (e == 0 && k == 2) begin
          nCmp++;
          if (valid_update_out !== 1'b0 || update_idx !== 2'd1 || update_data !== 2'b10) begin
            nFail++;
            $display("[TB] FAIL hold_slot2: got v=%b idx=%0d d=%b want v=0 idx=1 d=10",
                     valid_update_out, update_idx, update_data);
          end
        end
      end
    end
  endtask

  task automatic test_drop;
    int e;
    e = int'($urandom_range(0, 60)) - 30;
    valid_err_in = 1'b1; err_in = 16'(e);
    modelSweep(e, 1'b0);
    tick;
    for (int k = 0; k < N; k++) begin
      valid_err_in = (k == 1); resync = (k == 2); err_in = 16'sd100;
      tick;
      nCmp++;
      if (valid_update_out !== expV[k] || (expV[k] && (update_idx !== IW'(k) || update_data !== expC[k])) || err_drop !== (k == 1)) begin
        nFail++;
        $display("[TB] FAIL drop_sweep_slot%0d: got v=%b idx=%0d d=%b drop=%b want v=%b idx=%0d d=%b drop=%b",
                 k, valid_update_out, update_idx, update_data, err_drop, expV[k], k, expC[k], k == 1);
      end
    end
    valid_err_in = 1'b0; resync = 1'b0;
    tick;
    nCmp++;
    if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL drop_no_extra_sweep: got busy=%b want 0", busy); end
    resync = 1'b1; valid_err_in = 1'b1; err_in = 16'sd77;
    modelSweep(0, 1'b1);
    tick;
    resync = 1'b0; valid_err_in = 1'b0;
    nCmp++;
    if (err_drop !== 1'b1) begin nFail++; $display("[TB] FAIL drop_with_resync: got err_drop=%b want 1", err_drop); end
    for (int k = 0; k < N; k++) begin
      tick;
      nCmp++;
      if (valid_update_out !== 1'b1 || update_idx !== IW'(k) || update_data !== expC[k]) begin
        nFail++;
        $display("[TB] FAIL drop_resend_slot%0d: got v=%b idx=%0d d=%b want v=1 idx=%0d d=%b",
                 k, valid_update_out, update_idx, update_data, k, expC[k]);
      end
    end
  endtask

  // Data arriving mid-sweep must not alter that sweep, only the next one.
  task automatic test_random_with_data_in_sweep;
    int e;
    logic [1:0] c;
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j <= int'($urandom_range(0, 2)); j++) pushData(2'($urandom_range(0, 3)));
      e = int'($urandom_range(0, 120)) - 60;
      valid_err_in = 1'b1; err_in = 16'(e);
      modelSweep(e, 1'b0);
      tick;
      valid_err_in = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = 2'($urandom_range(0, 3));
        valid_data_in = (k == 1); data_in = c;
        if (k == 1) modelShift(c);
        tick;
        valid_data_in = 1'b0;
        nCmp++;
        if (valid_update_out !== expV[k] || (expV[k] && (update_idx !== IW'(k) || update_data !== expC[k])) || sweep_done !== (k == N - 1)) begin
          nFail++;
          $display("[TB] FAIL random%0d_slot%0d: got v=%b idx=%0d d=%b done=%b want v=%b idx=%0d d=%b done=%b",
                   it, k, valid_update_out, update_idx, update_data, sweep_done, expV[k], k, expC[k], k == N - 1);
        end
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_sweep;
    valid_err_in = 1'b1; err_in = 16'sd50;
    tick;
    valid_err_in = 1'b0;
    tick;
    tick;
    #2 reset_n = 1'b0;
    #1;
    nCmp++;
    if (valid_update_out !== 1'b0 || busy !== 1'b0 || sweep_done !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_mid_sweep: got v=%b busy=%b done=%b want 0 0 0", valid_update_out, busy, sweep_done);
    end
    modelClear();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    resync = 1'b1;
    modelSweep(0, 1'b1);
    tick;
    resync = 1'b0;
    for (int k = 0; k < N; k++) begin
      tick;
      nCmp++;
      if (valid_update_out !== 1'b1 || update_idx !== IW'(k) || update_data !== 2'b00) begin
        nFail++;
        $display("[TB] FAIL post_reset_resend_slot%0d: got v=%b idx=%0d d=%b want v=1 idx=%0d d=00",
                 k, valid_update_out, update_idx, update_data, k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_resync();
    test_directed_and_saturation();
    test_drop();
    test_random_with_data_in_sweep();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
